// File: rtl/layers_pkg.sv
// Shared types for the layer frame arbiter: FSM states and abort byte.
package layers_pkg;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    ABORT
  } arb_state_e;

  localparam logic [7:0] ABORT_BYTE_DEF = 8'hFF;
  localparam int TMO_W = 16;
  localparam int CNT_W = 16;

endpackage

// File: rtl/rr_select.sv
// Round-robin requester search: first request after the last-granted index.
module rr_select
  import layers_pkg::*;
#(
  parameter int N = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         update,
  input  logic [N-1:0] upd_gnt,
  output logic [N-1:0] gnt
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic [IW-1:0] ptr;
  logic [IW-1:0] upd_idx;
  logic          found;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    for (int k = 1; k <= N; k++) begin
      if (!found && req[(int'(ptr) + k) % N]) begin
        gnt[(int'(ptr) + k) % N] = 1'b1;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    upd_idx = ptr;
    for (int k = 0; k < N; k++) begin
      if (upd_gnt[k]) upd_idx = IW'(k);
    end
  end

  // Reset to the last index so layer 0 is the first winner.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= IW'(N - 1);
    end else if (update) begin
      ptr <= upd_idx;
    end
  end

endmodule

// File: rtl/layers_frame_arbiter.sv
// Frame-atomic round-robin merge of layer streams with idle timeout abort.
// Optional LAYERS_ARB_STATS_EN adds per-layer completed frame counters.
module layers_frame_arbiter
  import layers_pkg::*;
#(
  parameter int         LAYER_COUNT = 5,
  parameter logic [7:0] ABORT_BYTE  = ABORT_BYTE_DEF
) (
  input  logic                     clk_core,
  input  logic                     clk_core_resn,
  input  logic [LAYER_COUNT*8-1:0] s_axis_tdata,
  input  logic [LAYER_COUNT-1:0]   s_axis_tvalid,
  input  logic [LAYER_COUNT-1:0]   s_axis_tlast,
  output logic [LAYER_COUNT-1:0]   s_axis_tready,
  output logic [7:0]               m_axis_tdata,
  output logic [7:0]               m_axis_tdest,
  output logic                     m_axis_tvalid,
  output logic                     m_axis_tlast,
  input  logic                     m_axis_tready,
  input  logic [LAYER_COUNT-1:0]   cfg_layer_enable,
  input  logic [15:0]              cfg_frame_timeout,
  output logic [LAYER_COUNT-1:0]   status_grant,
  output logic [LAYER_COUNT-1:0]   stat_timeout
`ifdef LAYERS_ARB_STATS_EN
  ,
  output logic [LAYER_COUNT*16-1:0] stat_frame_count
`endif
);

  localparam int N = LAYER_COUNT;

  arb_state_e       state;
  arb_state_e       state_nxt;
  logic [N-1:0]     grant_nxt;
  logic [N-1:0]     skip;
  logic [N-1:0]     abort_done;
  logic [N-1:0]     req;
  logic [N-1:0]     rr_gnt;
  logic             rr_upd;
  logic [TMO_W-1:0] tmo_cnt;
  logic [TMO_W-1:0] tmo_nxt;
  logic             tmo_hit;
  logic             xfer;
  logic             sel_valid;
  logic             sel_last;
  logic [7:0]       sel_data;
  logic [7:0]       sel_dest;

  assign req = s_axis_tvalid & cfg_layer_enable & ~skip;

  rr_select #(
    .N(N)
  ) u_rr (
    .clk    (clk_core),
    .rst_n  (clk_core_resn),
    .req    (req),
    .update (rr_upd),
    .upd_gnt(status_grant),
    .gnt    (rr_gnt)
  );

  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    sel_dest  = '0;
    for (int k = 0; k < N; k++) begin
      if (status_grant[k]) begin
        sel_valid = s_axis_tvalid[k];
        sel_last  = s_axis_tlast[k];
        sel_data  = s_axis_tdata[k*8 +: 8];
        sel_dest  = 8'(k + 1);
      end
    end
  end

  assign tmo_hit = (cfg_frame_timeout != '0) &&
                   (tmo_cnt == cfg_frame_timeout);

  // Skipped layers are always drained, whatever the FSM is doing.
  always_comb begin
    state_nxt     = state;
    grant_nxt     = status_grant;
    rr_upd        = 1'b0;
    abort_done    = '0;
    xfer          = 1'b0;
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = '0;
    m_axis_tdest  = '0;
    m_axis_tlast  = 1'b0;
    s_axis_tready = skip;
    unique case (state)
      IDLE: begin
        if (|rr_gnt) begin
          grant_nxt = rr_gnt;
          state_nxt = GRANT;
        end
      end
      GRANT: begin
        m_axis_tvalid = sel_valid;
        m_axis_tdata  = sel_data;
        m_axis_tdest  = sel_dest;
        m_axis_tlast  = sel_last;
        s_axis_tready = skip |
          (status_grant & {N{m_axis_tready}});
        xfer = sel_valid & m_axis_tready;
        if (xfer && sel_last) begin
          state_nxt = IDLE;
          grant_nxt = '0;
          rr_upd    = 1'b1;
        end else if (!xfer && tmo_hit) begin
          state_nxt = ABORT;
        end
      end
      ABORT: begin
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = ABORT_BYTE;
        m_axis_tdest  = sel_dest;
        m_axis_tlast  = 1'b1;
        if (m_axis_tready) begin
          state_nxt  = IDLE;
          grant_nxt  = '0;
          rr_upd     = 1'b1;
          abort_done = status_grant;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    tmo_nxt = '0;
    if (state == GRANT) begin
      if (xfer) begin
        tmo_nxt = '0;
      end else if (!sel_valid) begin
        tmo_nxt = (&tmo_cnt) ? tmo_cnt : tmo_cnt + 1'b1;
      end else begin
        tmo_nxt = tmo_cnt;
      end
    end
  end

  always_ff @(posedge clk_core or negedge clk_core_resn) begin
    if (!clk_core_resn) begin
      state        <= IDLE;
      status_grant <= '0;
      skip         <= '0;
      tmo_cnt      <= '0;
      stat_timeout <= '0;
    end else begin
      state        <= state_nxt;
      status_grant <= grant_nxt;
      skip         <= (skip & ~(s_axis_tvalid & s_axis_tlast))
                      | abort_done;
      tmo_cnt      <= tmo_nxt;
      stat_timeout <= abort_done;
    end
  end

`ifdef LAYERS_ARB_STATS_EN
  always_ff @(posedge clk_core or negedge clk_core_resn) begin
    if (!clk_core_resn) begin
      stat_frame_count <= '0;
    end else begin
      for (int k = 0; k < N; k++) begin
        if (xfer && sel_last && status_grant[k]) begin
          stat_frame_count[k*16 +: 16] <=
            stat_frame_count[k*16 +: 16] + 16'd1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_layers_frame_arbiter.sv
// Randomized bench for layers_frame_arbiter against a frame-level
// round-robin model; expected beats are queued and matched in order.
module tb_layers_frame_arbiter;
  import layers_pkg::*;

  localparam int N = 5;

  typedef struct packed {
    logic [7:0] dest;
    logic [7:0] data;
    logic       last;
  } beat_t;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N*8-1:0] s_tdata = '0;
  logic [N-1:0]   s_tvalid = '0;
  logic [N-1:0]   s_tlast = '0;
  logic [N-1:0]   s_tready;
  logic [7:0]     m_tdata;
  logic [7:0]     m_tdest;
  logic           m_tvalid;
  logic           m_tlast;
  logic           m_tready = 1'b1;
  logic [N-1:0]   cfg_en = '1;
  logic [15:0]    cfg_tmo = '0;
  logic [N-1:0]   grant;
  logic [N-1:0]   stat_tmo;
`ifdef LAYERS_ARB_STATS_EN
  logic [N*16-1:0] frame_cnt;
`endif

  logic [8:0]   srcq [N][$];
  beat_t        expq [$];
  bit           hold [N];
  int           tmo_seen [N];
  int           exp_frames [N];
  logic [N-1:0] en_cfg = '1;
  logic [15:0]  tmo_cfg = '0;
  int           rdy_mode = 0;
  int           ref_last = N - 1;
  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  int           abort_cyc = 0;
  int           bad1 = 0;
  bit           watch1 = 0;
  bit           prev_last = 0;

  always #5 clk = ~clk;

  layers_frame_arbiter #(
    .LAYER_COUNT(N)
  ) dut (
    .clk_core         (clk),
    .clk_core_resn    (rst_n),
    .s_axis_tdata     (s_tdata),
    .s_axis_tvalid    (s_tvalid),
    .s_axis_tlast     (s_tlast),
    .s_axis_tready    (s_tready),
    .m_axis_tdata     (m_tdata),
    .m_axis_tdest     (m_tdest),
    .m_axis_tvalid    (m_tvalid),
    .m_axis_tlast     (m_tlast),
    .m_axis_tready    (m_tready),
    .cfg_layer_enable (cfg_en),
    .cfg_frame_timeout(cfg_tmo),
    .status_grant     (grant),
    .stat_timeout     (stat_tmo)
`ifdef LAYERS_ARB_STATS_EN
    ,
    .stat_frame_count (frame_cnt)
`endif
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic load_frame(input int l, input int len);
    for (int j = 0; j < len; j++)
      srcq[l].push_back({(j == len - 1), 8'($urandom)});
  endtask

  // Reference: whole frames in round-robin order after the last winner.
  task automatic build_expected(input logic [N-1:0] en);
    logic [8:0] cp [N][$];
    logic [8:0] b;
    int pick;
    for (int k = 0; k < N; k++) cp[k] = srcq[k];
    while (1) begin
      pick = -1;
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (ref_last + k) % N;
        if (pick < 0 && en[c] && cp[c].size() > 0) pick = c;
      end
      if (pick < 0) break;
      do begin
        b = cp[pick].pop_front();
        expq.push_back('{dest: 8'(pick + 1),
                         data: b[7:0], last: b[8]});
      end while (!b[8]);
      exp_frames[pick]++;
      ref_last = pick;
    end
  endtask

  task automatic step();
    logic [8:0] b;
    beat_t e;
    @(negedge clk);
    rst_n   = 1'b1;
    cfg_en  = en_cfg;
    cfg_tmo = tmo_cfg;
    if (rdy_mode == 0) m_tready = 1'b1;
    else if (rdy_mode == 1) m_tready = ($urandom_range(0, 3) != 0);
    else m_tready = ~m_tready;
    for (int i = 0; i < N; i++) begin
      if (!hold[i] && srcq[i].size() > 0) begin
        b = srcq[i][0];
        s_tvalid[i] = 1'b1;
        s_tdata[i*8 +: 8] = b[7:0];
        s_tlast[i] = b[8];
      end else begin
        s_tvalid[i] = 1'b0;
        s_tdata[i*8 +: 8] = '0;
        s_tlast[i] = 1'b0;
      end
    end
    #4;
    cyc++;
    if (prev_last) check("idle_gap", m_tvalid, 0);
    prev_last = m_tvalid && m_tready && m_tlast;
    if (m_tvalid)
      check("grant_match", grant, 32'd1 << (m_tdest - 8'd1));
    if (m_tvalid && m_tready) begin
      check("exp_nonempty", expq.size() != 0, 1);
      if (expq.size() != 0) begin
        e = expq.pop_front();
        check("beat", {m_tdest, m_tdata, m_tlast}, e);
      end
      if (m_tlast && m_tdata == 8'hFF && m_tdest == 8'd2)
        abort_cyc = cyc;
    end
    for (int i = 0; i < N; i++) begin
      if (s_tvalid[i] && s_tready[i]) void'(srcq[i].pop_front());
      tmo_seen[i] += int'(stat_tmo[i]);
    end
    if (watch1 && (s_tready[1] || grant[1])) bad1++;
  endtask

  task automatic drain(input logic [N-1:0] en, output int n);
    bit pend;
    n = 0;
    do begin
      pend = expq.size() != 0;
      for (int i = 0; i < N; i++)
        if (en[i] && srcq[i].size() > 0) pend = 1;
      if (pend) begin
        step();
        n++;
      end
    end while (pend && n < 2000);
    check("drain_pending", expq.size(), 0);
  endtask

  initial begin
    int n;
    int k;
    for (int i = 0; i < N; i++) begin
      hold[i] = 0;
      tmo_seen[i] = 0;
      exp_frames[i] = 0;
    end
    #1;
    check("rst_state",
          {m_tvalid, m_tdata, m_tdest, m_tlast,
           grant, s_tready, stat_tmo}, 0);
    repeat (2) @(posedge clk);

    // All five layers offer one 3-byte frame at once.
    for (int i = 0; i < N; i++) load_frame(i, 3);
    build_expected('1);
    drain('1, n);
    check("rr5_cycles", n, 20);

    // Frame atomicity under toggling downstream ready.
    rdy_mode = 2;
    load_frame(2, 4);
    load_frame(3, 2);
    build_expected('1);
    drain('1, n);

    // Disabled layer 1 must never be granted or readied.
    rdy_mode = 0;
    en_cfg = 5'b11101;
    watch1 = 1;
    for (int i = 0; i < N; i++) load_frame(i, 2);
    build_expected(5'b11101);
    drain(5'b11101, n);
    check("l1_disabled", bad1, 0);
    watch1 = 0;
    srcq[1].delete();
    step();

    // Random rounds with random enables and backpressure.
    rdy_mode = 1;
    for (int r = 0; r < 8; r++) begin
      en_cfg = N'($urandom_range(1, (1 << N) - 1));
      for (int i = 0; i < N; i++)
        if (en_cfg[i]) begin
          int nf;
          nf = $urandom_range(0, 3);
          for (int f = 0; f < nf; f++)
            load_frame(i, $urandom_range(1, 5));
        end
      build_expected(en_cfg);
      drain(en_cfg, n);
    end

    // Timeout: layer 1 stalls after two bytes.
    rdy_mode = 0;
    en_cfg = '1;
    tmo_cfg = 16'd10;
    abort_cyc = 0;
    load_frame(1, 5);
    expq.push_back('{dest: 8'd2, data: srcq[1][0][7:0], last: 1'b0});
    expq.push_back('{dest: 8'd2, data: srcq[1][1][7:0], last: 1'b0});
    expq.push_back('{dest: 8'd2, data: 8'hFF, last: 1'b1});
    n = 0;
    while (srcq[1].size() > 3 && n < 50) begin
      step();
      n++;
    end
    k = cyc;
    hold[1] = 1;
    n = 0;
    while (abort_cyc == 0 && n < 80) begin
      step();
      n++;
    end
    check("tmo_latency", abort_cyc - k, 12);
    step();
    check("tmo_pulse", stat_tmo, 5'b00010);
    step();
    check("tmo_pulse_end", stat_tmo, 0);
    hold[1] = 0;
    repeat (6) step();
    check("tmo_sunk", srcq[1].size(), 0);
    check("tmo_expq", expq.size(), 0);
    check("tmo_count", tmo_seen[1], 1);
    check("tmo_other",
          tmo_seen[0] + tmo_seen[2] + tmo_seen[3] + tmo_seen[4], 0);
    tmo_cfg = 0;
    ref_last = 1;
    load_frame(1, 3);
    build_expected('1);
    drain('1, n);

    // Reset in the middle of a layer 3 frame.
    load_frame(3, 6);
    expq.push_back('{dest: 8'd4, data: srcq[3][0][7:0], last: 1'b0});
    expq.push_back('{dest: 8'd4, data: srcq[3][1][7:0], last: 1'b0});
    n = 0;
    while (srcq[3].size() > 4 && n < 50) begin
      step();
      n++;
    end
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid",
          {m_tvalid, m_tdata, m_tdest, m_tlast,
           grant, s_tready, stat_tmo}, 0);
    check("rst_expq", expq.size(), 0);
    ref_last = N - 1;
    prev_last = 0;
    for (int i = 0; i < N; i++) exp_frames[i] = 0;
    repeat (2) @(posedge clk);
    load_frame(0, 2);
    build_expected('1);
    check("rst_first_dest", expq[0].dest, 1);
    drain('1, n);

`ifdef LAYERS_ARB_STATS_EN
    step();
    for (int i = 0; i < N; i++)
      check("frame_count", frame_cnt[i*16 +: 16],
            32'(exp_frames[i] % 65536));
`endif

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
